// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: registered clk_out plus a tick at each period start; new ratios are applied only at a period boundary.
// Latency: clk_out and tick follow the edge that samples en high by one cycle; a config applies at the next wrap, or on the next edge while idle.
// Backpressure: cfg_ready is low while a config is pending; an illegal request (cfg_div < 2) is rejected with a one-cycle cfg_err pulse.
module clk_div_prog #(
    parameter int WIDTH        = 16,
    parameter int DEFAULT_DIV  = 2,
    parameter int DEFAULT_HIGH = 1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick
);

    localparam int HIGH_CLAMPED = (DEFAULT_HIGH < 1) ? 1 :
                                  (DEFAULT_HIGH >= DEFAULT_DIV) ? DEFAULT_DIV - 1 : DEFAULT_HIGH;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);
    localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(HIGH_CLAMPED);
    localparam logic [WIDTH-1:0] RST_CNT  = WIDTH'(DEFAULT_DIV - 1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_cur;
    logic [WIDTH-1:0] high_cur;
    logic [WIDTH-1:0] pend_div;
    logic [WIDTH-1:0] pend_high;
    logic             pend;

    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] high_req;
    logic             wrap;
    logic             accept;
    logic             reject;

    assign cfg_ready = ~pend;
    assign cnt_inc   = cnt + ONE;
    assign wrap      = (cnt == div_cur - ONE);
    assign accept    = cfg_valid && cfg_ready;
    assign reject    = accept && (cfg_div < TWO);

    // High time is clamped into 1..cfg_div-1 so every period has both phases.
    always_comb begin
        high_req = cfg_high;
        if (cfg_high == '0) begin
            high_req = ONE;
        end else if (cfg_high >= cfg_div) begin
            high_req = cfg_div - ONE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= RST_CNT;
            div_cur   <= RST_DIV;
            high_cur  <= RST_HIGH;
            pend_div  <= '0;
            pend_high <= '0;
            pend      <= 1'b0;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= reject;

            if (!en) begin
                // Idle: truncate the period and prime the counter so the next enabled edge wraps.
                clk_out <= 1'b0;
                tick    <= 1'b0;
                if (pend) begin
                    div_cur  <= pend_div;
                    high_cur <= pend_high;
                    cnt      <= pend_div - ONE;
                    pend     <= 1'b0;
                end else begin
                    cnt <= div_cur - ONE;
                end
            end else if (wrap) begin
                cnt     <= '0;
                clk_out <= 1'b1;
                tick    <= 1'b1;
                if (pend) begin
                    div_cur  <= pend_div;
                    high_cur <= pend_high;
                    pend     <= 1'b0;
                end
            end else begin
                cnt     <= cnt_inc;
                clk_out <= (cnt_inc < high_cur);
                tick    <= 1'b0;
            end

            // Accept never collides with an apply: accept needs pend low, apply needs it high.
            if (accept && !reject) begin
                pend_div  <= cfg_div;
                pend_high <= high_req;
                pend      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios plus random traffic, checked every cycle against a period/phase reference model.
module tb_clk_div_prog;

    localparam int WIDTH = 16;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_div;
    logic [WIDTH-1:0] cfg_high;
    logic             cfg_err;
    logic             clk_out;
    logic             tick;

    clk_div_prog #(
        .WIDTH        (WIDTH),
        .DEFAULT_DIV  (4),
        .DEFAULT_HIGH (2)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clk_in = ~clk_in;

    int chk_cnt  = 0;
    int fail_cnt = 0;

    // Reference model: active period/high, position within the current period, one pending slot.
    int m_div, m_high, m_pos, m_pdiv, m_phigh;
    bit m_primed, m_pend, m_clk, m_tick, m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_div = 4; m_high = 2; m_pos = 0; m_primed = 1'b1;
        m_pend = 1'b0; m_pdiv = 0; m_phigh = 0;
        m_clk = 1'b0; m_tick = 1'b0; m_err = 1'b0;
    endtask

    function automatic int clamp_high(input int d, input int h);
        if (h == 0) return 1;
        if (h >= d) return d - 1;
        return h;
    endfunction

    task automatic model_edge();
        bit acc;
        acc   = cfg_valid && !m_pend;
        m_err = acc && (int'(cfg_div) < 2);
        if (!en) begin
            if (m_pend) begin
                m_div = m_pdiv; m_high = m_phigh; m_pend = 1'b0;
            end
            m_primed = 1'b1;
            m_clk    = 1'b0;
            m_tick   = 1'b0;
        end else begin
            if (m_primed || m_pos == m_div - 1) begin
                if (m_pend) begin
                    m_div = m_pdiv; m_high = m_phigh; m_pend = 1'b0;
                end
                m_pos    = 0;
                m_primed = 1'b0;
            end else begin
                m_pos++;
            end
            m_clk  = (m_pos < m_high);
            m_tick = (m_pos == 0);
        end
        if (acc && int'(cfg_div) >= 2) begin
            m_pend  = 1'b1;
            m_pdiv  = int'(cfg_div);
            m_phigh = clamp_high(int'(cfg_div), int'(cfg_high));
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".clk_out"},   32'(clk_out),   32'(m_clk));
        chk({tag, ".tick"},      32'(tick),      32'(m_tick));
        chk({tag, ".cfg_err"},   32'(cfg_err),   32'(m_err));
        chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(!m_pend));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk_in);
        #1;
        check_outputs(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic send_cfg(input string tag, input int d, input int h);
        cfg_valid = 1'b1;
        cfg_div   = WIDTH'(d);
        cfg_high  = WIDTH'(h);
        step(tag);
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_high = '0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk_in);
        rst_n = 1'b1;
        #1;

        // 1: default 4/2 pattern; explicit check of the 1,1,0,0 shape alongside the model
        en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step("t1");
            chk("t1.shape", 32'(clk_out), 32'((k % 4) < 2));
        end

        // 2: reconfigure to 5/3 mid-period
        run("t2.pre", 1);
        send_cfg("t2.acc", 5, 3);
        run("t2", 14);

        // 3: illegal dividers are rejected
        send_cfg("t3.div1", 1, 1);
        send_cfg("t3.div0", 0, 0);
        run("t3", 6);

        // 4: high-time clamping in both directions
        send_cfg("t4.lo", 6, 0);
        run("t4.lo", 14);
        send_cfg("t4.hi", 6, 9);
        run("t4.hi", 14);

        // 5: drop en mid-high at div=8, then re-enable
        send_cfg("t5.cfg", 8, 4);
        while (m_pend || m_pos != 0) step("t5.sync");
        step("t5.high");
        en = 1'b0;
        step("t5.drop");
        chk("t5.drop_clk", 32'(clk_out), 32'(0));
        run("t5.idle", 3);
        en = 1'b1;
        run("t5.re", 17);

        // 6: async reset with a config pending
        send_cfg("t6.cfg", 7, 3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("t6.rst");
        @(negedge clk_in);
        rst_n = 1'b1;
        #1;
        run("t6.after", 12);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            en        = ($urandom_range(0, 15) != 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_div   = WIDTH'($urandom_range(0, 12));
            cfg_high  = WIDTH'($urandom_range(0, 14));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable integer clock divider, the parametrised successor to the fixed-ratio divider. It produces a divided clock-enable style output `clk_out` with a programmable period and high time, plus a one-cycle `tick` strobe at each period start. New ratios are loaded through a valid/ready handshake and take effect only at a period boundary, so there are no runt pulses. It feeds the DSM modulator and sample-rate logic from the single system clock.

Parameters:
WIDTH, 16, width of counter and config fields; legal range 2..32.
DEFAULT_DIV, 2, period in `clk_in` cycles after reset; must be ≥2 and <2^WIDTH.
DEFAULT_HIGH, 1, high time in cycles after reset; clamped into 1..DEFAULT_DIV-1.

Ports:
clk_in  input  1  system clock; all logic on its rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  run enable; low means idle.
cfg_valid  input  1  config request.
cfg_ready  output  1  high when no config is pending.
cfg_div  input  WIDTH  requested period in `clk_in` cycles.
cfg_high  input  WIDTH  requested high time in cycles.
cfg_err  output  1  one-cycle pulse when a config is rejected.
clk_out  output  1  divided clock, registered.
tick  output  1  one-cycle pulse coincident with each `clk_out` rising period start.

Behaviour:
- State:
  - `cnt` [WIDTH].
  - `div_cur` and `high_cur` (active settings).
  - `pend_div` and `pend_high` plus a `pend` flag (pending settings).
- Reset (async, `rst_n` = 0):
  - `div_cur` = DEFAULT_DIV; `high_cur` = clamped DEFAULT_HIGH; `cnt` = DEFAULT_DIV-1.
  - `pend` = 0; `cfg_ready` = 1; `clk_out` = 0; `tick` = 0; `cfg_err` = 0.
- Running (`en` = 1), each edge:
  - If `cnt == div_cur-1` (wrap): `cnt` <= 0, `clk_out` <= 1, `tick` <= 1.
  - Else: `cnt` <= `cnt`+1, `clk_out` <= (`cnt`+1 < `high_cur`), `tick` <= 0.
- Resulting output:
  - Period is exactly `div_cur` cycles.
  - `clk_out` is high for `high_cur` cycles, then low for `div_cur`-`high_cur` cycles.
- Idle (`en` = 0):
  - `cnt` <= `div_cur`-1 (primed); `clk_out` <= 0; `tick` <= 0.
  - Deasserting `en` mid-period truncates that period immediately; no completion.
  - On the first enabled edge after idle, the counter wraps: `clk_out` rises and `tick` pulses one cycle after `en` is sampled high.
- Config handshake:
  - Transfer occurs when `cfg_valid` && `cfg_ready` at an edge.
  - If `cfg_div` < 2: reject. Nothing is stored, `cfg_err` = 1 for one cycle, `cfg_ready` stays 1.
  - Otherwise: `pend_div` <= `cfg_div`; `pend_high` <= clamp(`cfg_high`), where 0→1 and ≥`cfg_div`→`cfg_div`-1. Then `pend` <= 1 and `cfg_ready` <= 0.
- Applying a pending config:
  - Running: applied at the next wrap edge. That same edge loads `div_cur`/`high_cur` from pending, sets `cnt` <= 0, `clk_out` <= 1, `tick` <= 1, and clears `pend`. `cfg_ready` returns to 1 on the following cycle.
  - Idle: applied on the next edge, with `cnt` <= `pend_div`-1.
- Simultaneous events:
  - Accept on the same edge as a wrap: the new config is not applied at that wrap; it waits for the next wrap.
  - Wrap and apply while `cfg_valid` is held: the request is accepted on the edge after `cfg_ready` rises.
- Width rules:
  - All compares are unsigned in WIDTH bits.
  - Maximum period is 2^WIDTH-1; `cnt` never exceeds `div_cur`-1, so no overflow is possible.
- Reset mid-operation: all state returns to reset values immediately, and any pending config is discarded.

Test Plan:
1. Reset with DIV=4, HIGH=2, then `en`=1 → `clk_out` pattern 1,1,0,0 repeating; `tick` every 4th cycle, aligned with each `clk_out` rise.
2. Running at div=4, send `cfg_div`=5, `cfg_high`=3 mid-period → old period completes untouched. Then 1,1,1,0,0 repeating. `cfg_ready` is low from accept until one cycle after the wrap.
3. Send `cfg_div`=1, then `cfg_div`=0 → `cfg_err` pulses each time, `cfg_ready` stays 1, output is unchanged.
4. Clamp: `cfg_div`=6, `cfg_high`=0 → high 1 of 6 cycles. `cfg_div`=6, `cfg_high`=9 → high 5 of 6 cycles.
5. Drop `en` mid-high phase at div=8 → `clk_out` goes 0 the next cycle and `tick` stays 0. Re-enable → rise and `tick` one cycle after `en`, with a full 8-cycle period.
6. Assert `rst_n`=0 asynchronously with a config pending → outputs 0 immediately, `cfg_ready`=1, DEFAULT_DIV restored, pending config is never applied.
